// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared types and constants for the ID forwarding scoreboard
//
// Purpose: data width, writer-class codes, in-flight entry layout, forward-source select
//          and the forward data mux used by fwd_scoreboard and fwd_match.
// Ports:   none (package).
package fwd_scoreboard_pkg;

  localparam int         W_DATA    = 32;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Writer classes; code 3 is unused and treated like a load (never forwarded from EX).
  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_MDU  = 2'd2;

  typedef struct packed {
    logic       v;
    logic [4:0] waddr;
    logic [1:0] kind;
  } entry_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_EX   = 2'd1,
    SEL_MEM  = 2'd2,
    SEL_WB   = 2'd3
  } fwd_sel_e;

  // Forward data is forced to zero whenever no source is selected.
  function automatic logic [W_DATA-1:0] pick_data(
    input fwd_sel_e          sel,
    input logic [W_DATA-1:0] ex_d,
    input logic [W_DATA-1:0] mem_d,
    input logic [W_DATA-1:0] wb_d
  );
    case (sel)
      SEL_EX:  pick_data = ex_d;
      SEL_MEM: pick_data = mem_d;
      SEL_WB:  pick_data = wb_d;
      default: pick_data = '0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - ID-stage operand/result bus bundle for the forwarding scoreboard
//
// Purpose: groups the ID instruction fields, the per-stage result buses and the
//          forwarding/stall outputs.
// Modports:
//   master - decoder/pipeline side: drives id_* and the result buses, reads forward_*/stall/mdu_busy
//   slave  - scoreboard side: the reverse
interface fwd_scoreboard_if;
  import fwd_scoreboard_pkg::*;

  logic              id_valid;
  logic              id_wreg;
  logic [4:0]        id_waddr;
  logic [1:0]        id_kind;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [W_DATA-1:0] ex_data;
  logic [W_DATA-1:0] mem_data;
  logic [W_DATA-1:0] wb_data;
  logic              forward_rs;
  logic              forward_rt;
  logic [W_DATA-1:0] forward_rs_data;
  logic [W_DATA-1:0] forward_rt_data;
  logic              stall;
  logic              mdu_busy;

  modport master (
    output id_valid, id_wreg, id_waddr, id_kind, id_use_rs, id_use_rt, id_rs, id_rt,
    output ex_data, mem_data, wb_data,
    input  forward_rs, forward_rt, forward_rs_data, forward_rt_data, stall, mdu_busy
  );

  modport slave (
    input  id_valid, id_wreg, id_waddr, id_kind, id_use_rs, id_use_rt, id_rs, id_rt,
    input  ex_data, mem_data, wb_data,
    output forward_rs, forward_rt, forward_rs_data, forward_rt_data, stall, mdu_busy
  );

endinterface

// File: rtl/fwd_scoreboard_match.sv
// rtl/fwd_scoreboard_match.sv - per-operand hazard/forward decision against EX/MEM/WB writers
//
// Purpose: for one source operand, find the youngest in-flight writer of that register and
//          decide forward (with source select) or stall. Instantiated once for rs, once for rt.
// Ports:
//   ex_e, mem_e        in  EX and MEM writer entries
//   wb_v, wb_waddr     in  WB writer valid/address (WB class is irrelevant)
//   mdu_done           in  MDU counter is zero, EX MDU result is valid
//   use_reg, addr      in  operand is read / its register address
//   fwd, stall, sel    out forward request, stall request, forward source
// Config: FWD_WB_BYPASS_EN defined -> WB writers are forwarded; otherwise the regfile
//         write-before-read supplies the value and a WB hit does nothing.
module fwd_match
  import fwd_scoreboard_pkg::*;
#(
  parameter bit EX_FWD = 1'b1
) (
  input  entry_t     ex_e,
  input  entry_t     mem_e,
  input  logic       wb_v,
  input  logic [4:0] wb_waddr,
  input  logic       mdu_done,
  input  logic       use_reg,
  input  logic [4:0] addr,
  output logic       fwd,
  output logic       stall,
  output fwd_sel_e   sel
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_e.v  && (ex_e.waddr  == addr);
  assign mem_hit = mem_e.v && (mem_e.waddr == addr);
  assign wb_hit  = wb_v    && (wb_waddr    == addr);

  // Priority chain: a younger hit shadows any older one, even when the younger one stalls.
  always_comb begin
    sel   = SEL_NONE;
    stall = 1'b0;
    if (use_reg && (addr != REG_ZERO)) begin
      if (ex_hit) begin
        if ((ex_e.kind == KIND_ALU) && EX_FWD) begin
          sel = SEL_EX;
        end else if ((ex_e.kind == KIND_MDU) && mdu_done) begin
          sel = SEL_EX;
        end else begin
          stall = 1'b1;
        end
      end else if (mem_hit) begin
        // Load data only appears on the WB bus.
        if (mem_e.kind == KIND_LOAD) begin
          stall = 1'b1;
        end else begin
          sel = SEL_MEM;
        end
      end else if (wb_hit) begin
`ifdef FWD_WB_BYPASS_EN
        sel = SEL_WB;
`else
        sel = SEL_NONE;
`endif
      end
    end
  end

  assign fwd = (sel != SEL_NONE);

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - ID-stage forwarding/hazard scoreboard tracking EX/MEM/WB writers
//
// Purpose: shadows the register writers in EX, MEM and WB, holds EX while a multi-cycle
//          MDU op completes, and drives forward_rs/rt, forward data and stall for ID.
// Ports:
//   clk         in  rising-edge clock
//   resetn      in  asynchronous active-low reset
//   pipe_stall  in  external freeze; holds entries and the MDU counter
//   flush       in  exception flush; clears EX/MEM and the counter, WB retires
//   sb          slave modport of fwd_scoreboard_if (ID fields, result buses, outputs)
// Parameters: MDU_LAT (>=1) cycles an MDU op occupies EX; EX_FWD 1 forwards ALU results from EX.
// Config macro: FWD_WB_BYPASS_EN - forward WB writers (regfile not write-through).
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int EX_FWD  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pipe_stall,
  input  logic            flush,
  fwd_scoreboard_if.slave sb
);

  localparam int             CNT_W    = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  entry_t           ex_e;
  entry_t           mem_e;
  logic             wb_v;
  logic [4:0]       wb_waddr;
  logic [CNT_W-1:0] cnt;
  entry_t           issue;
  logic             mdu_busy;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_any;
  logic             fwd_rs;
  logic             fwd_rt;
  fwd_sel_e         sel_rs;
  fwd_sel_e         sel_rt;

  assign mdu_busy  = (cnt != '0);
  assign stall_any = stall_rs | stall_rt;

  // A stalled ID instruction enters EX as a bubble; $0 writes are never tracked.
  always_comb begin
    issue = '0;
    if (sb.id_valid && sb.id_wreg && (sb.id_waddr != REG_ZERO) && !stall_any) begin
      issue.v     = 1'b1;
      issue.waddr = sb.id_waddr;
      issue.kind  = sb.id_kind;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_e     <= '0;
      mem_e    <= '0;
      wb_v     <= 1'b0;
      wb_waddr <= '0;
      cnt      <= '0;
    end else if (flush) begin
      // The WB writer retires; the flushed MEM slot brings nothing behind it.
      ex_e  <= '0;
      mem_e <= '0;
      wb_v  <= 1'b0;
      cnt   <= '0;
    end else if (!pipe_stall) begin
      if (mdu_busy) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        wb_v     <= mem_e.v;
        wb_waddr <= mem_e.waddr;
        mem_e    <= ex_e;
        ex_e     <= issue;
        if (issue.v && (issue.kind == KIND_MDU)) begin
          cnt <= CNT_LOAD;
        end
      end
    end
  end

  fwd_match #(.EX_FWD(EX_FWD != 0)) u_match_rs (
    .ex_e     (ex_e),
    .mem_e    (mem_e),
    .wb_v     (wb_v),
    .wb_waddr (wb_waddr),
    .mdu_done (!mdu_busy),
    .use_reg  (sb.id_use_rs),
    .addr     (sb.id_rs),
    .fwd      (fwd_rs),
    .stall    (stall_rs),
    .sel      (sel_rs)
  );

  fwd_match #(.EX_FWD(EX_FWD != 0)) u_match_rt (
    .ex_e     (ex_e),
    .mem_e    (mem_e),
    .wb_v     (wb_v),
    .wb_waddr (wb_waddr),
    .mdu_done (!mdu_busy),
    .use_reg  (sb.id_use_rt),
    .addr     (sb.id_rt),
    .fwd      (fwd_rt),
    .stall    (stall_rt),
    .sel      (sel_rt)
  );

  assign sb.forward_rs      = fwd_rs;
  assign sb.forward_rt      = fwd_rt;
  assign sb.forward_rs_data = pick_data(sel_rs, sb.ex_data, sb.mem_data, sb.wb_data);
  assign sb.forward_rt_data = pick_data(sel_rt, sb.ex_data, sb.mem_data, sb.wb_data);
  assign sb.stall           = stall_any;
  assign sb.mdu_busy        = mdu_busy;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - table-driven scoreboard bench for fwd_scoreboard
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int MDU_LAT = 4;
`ifdef FWD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int S_NO = 0, S_EX = 1, S_MEM = 2, S_WB = 3;

  typedef struct {
    string      name;
    logic       ps, fl, iv;
    logic [1:0] kd;
    logic [4:0] wa;
    logic       urs;
    logic [4:0] rs;
    logic       urt;
    logic [4:0] rt;
    int         srs, srt;
    logic       st, bu;
  } vec_t;

  typedef struct {
    string       name;
    logic        frs, frt;
    logic [31:0] drs, drt;
    logic        st, bu;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pipe_stall = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sbq[$];

  fwd_scoreboard_if bus ();

  fwd_scoreboard #(.MDU_LAT(MDU_LAT), .EX_FWD(1)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_stall (pipe_stall),
    .flush      (flush),
    .sb         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(string n, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic chk32(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, int ps, int fl, int iv, int kd, int wa,
                              int urs, int rs, int urt, int rt,
                              int srs, int srt, int st, int bu);
    vec_t v;
    v.name = n;
    v.ps = ps[0]; v.fl = fl[0]; v.iv = iv[0]; v.kd = kd[1:0]; v.wa = wa[4:0];
    v.urs = urs[0]; v.rs = rs[4:0]; v.urt = urt[0]; v.rt = rt[4:0];
    v.srs = srs; v.srt = srt; v.st = st[0]; v.bu = bu[0];
    return v;
  endfunction

  function automatic logic [31:0] ex_val(int idx);  return 32'hE000_0000 + 32'(idx); endfunction
  function automatic logic [31:0] mem_val(int idx); return 32'h4000_0000 + 32'(idx); endfunction
  function automatic logic [31:0] wb_val(int idx);  return 32'hB000_0000 + 32'(idx); endfunction

  // Without the WB bypass a WB hit supplies nothing.
  function automatic logic [31:0] src_data(int s, int idx);
    case (s)
      S_EX:    return ex_val(idx);
      S_MEM:   return mem_val(idx);
      S_WB:    return BYP ? wb_val(idx) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic src_fwd(int s);
    return (s == S_EX) || (s == S_MEM) || ((s == S_WB) && BYP);
  endfunction

  task automatic drive(vec_t v, int idx);
    pipe_stall       = v.ps;
    flush            = v.fl;
    bus.id_valid     = v.iv;
    bus.id_wreg      = v.iv;
    bus.id_kind      = v.kd;
    bus.id_waddr     = v.wa;
    bus.id_use_rs    = v.urs;
    bus.id_rs        = v.rs;
    bus.id_use_rt    = v.urt;
    bus.id_rt        = v.rt;
    bus.ex_data      = ex_val(idx);
    bus.mem_data     = mem_val(idx);
    bus.wb_data      = wb_val(idx);
  endtask

  task automatic check_outputs(exp_t e);
    chk1 ({e.name, "/forward_rs"},      bus.forward_rs,      e.frs);
    chk1 ({e.name, "/forward_rt"},      bus.forward_rt,      e.frt);
    chk32({e.name, "/forward_rs_data"}, bus.forward_rs_data, e.drs);
    chk32({e.name, "/forward_rt_data"}, bus.forward_rt_data, e.drt);
    chk1 ({e.name, "/stall"},           bus.stall,           e.st);
    chk1 ({e.name, "/mdu_busy"},        bus.mdu_busy,        e.bu);
  endtask

  initial begin
    exp_t e;
    exp_t got;
    int   cycles;

    //            name            ps fl iv kind       wa urs rs urt rt  srs    srt    st bu
    vecs.push_back(mk("alu8",       0,0,1,KIND_ALU, 8,  0,0, 0,0,   S_NO,  S_NO,  0,0));
    vecs.push_back(mk("t1_rs_ex",   0,0,1,KIND_ALU, 11, 1,8, 0,0,   S_EX,  S_NO,  0,0));
    vecs.push_back(mk("rs_mem",     0,0,1,KIND_ALU, 8,  1,8, 1,11,  S_MEM, S_EX,  0,0));
    vecs.push_back(mk("rs_ex",      0,0,1,KIND_ALU, 8,  1,8, 1,11,  S_EX,  S_MEM, 0,0));
    vecs.push_back(mk("t4_ex_wins", 0,0,1,KIND_ALU, 0,  1,8, 1,11,  S_EX,  S_WB,  0,0));
    vecs.push_back(mk("t4_rs_zero", 0,0,0,KIND_ALU, 0,  1,0, 1,8,   S_NO,  S_MEM, 0,0));
    vecs.push_back(mk("wb_only",    0,0,0,KIND_ALU, 0,  1,8, 0,8,   S_WB,  S_NO,  0,0));
    vecs.push_back(mk("ld9",        0,0,1,KIND_LOAD,9,  0,0, 0,0,   S_NO,  S_NO,  0,0));
    vecs.push_back(mk("t2_ld_ex",   0,0,1,KIND_ALU, 12, 0,0, 1,9,   S_NO,  S_NO,  1,0));
    vecs.push_back(mk("t2_ld_mem",  0,0,1,KIND_ALU, 12, 0,0, 1,9,   S_NO,  S_NO,  1,0));
    vecs.push_back(mk("t2_ld_wb",   0,0,1,KIND_ALU, 12, 0,0, 1,9,   S_NO,  S_WB,  0,0));
    vecs.push_back(mk("mdu10",      0,0,1,KIND_MDU, 10, 0,0, 0,0,   S_NO,  S_NO,  0,0));
    for (int i = 0; i < MDU_LAT - 1; i++)
      vecs.push_back(mk("t3_busy",  0,0,1,KIND_ALU, 13, 1,10,1,12,  S_NO,  S_MEM, 1,1));
    vecs.push_back(mk("t3_mdu_fwd", 0,0,1,KIND_ALU, 13, 1,10,1,12,  S_EX,  S_MEM, 0,0));
    vecs.push_back(mk("mdu_in_mem", 0,0,0,KIND_ALU, 0,  1,10,1,13,  S_MEM, S_EX,  0,0));
    vecs.push_back(mk("ld9_b",      0,0,1,KIND_LOAD,9,  0,0, 0,0,   S_NO,  S_NO,  0,0));
    vecs.push_back(mk("mdu10_b",    0,0,1,KIND_MDU, 10, 0,0, 0,0,   S_NO,  S_NO,  0,0));
    vecs.push_back(mk("t5_flush",   1,1,0,KIND_ALU, 0,  1,9, 1,10,  S_NO,  S_NO,  1,1));
    vecs.push_back(mk("t5_after",   0,0,0,KIND_ALU, 0,  1,9, 1,10,  S_NO,  S_NO,  0,0));
    vecs.push_back(mk("alu14",      0,0,1,KIND_ALU, 14, 0,0, 0,0,   S_NO,  S_NO,  0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("t6_hold",  1,0,1,KIND_ALU, 15, 1,14,0,0,   S_EX,  S_NO,  0,0));
    vecs.push_back(mk("t6_release", 0,0,1,KIND_ALU, 15, 1,14,0,0,   S_EX,  S_NO,  0,0));
    vecs.push_back(mk("t6_after",   0,0,0,KIND_ALU, 0,  1,14,1,15,  S_MEM, S_EX,  0,0));
    vecs.push_back(mk("mdu16",      0,0,1,KIND_MDU, 16, 0,0, 0,0,   S_NO,  S_NO,  0,0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk("cnt_frozen",1,0,0,KIND_ALU,0,  1,16,0,0,   S_NO,  S_NO,  1,1));
    for (int i = 0; i < MDU_LAT - 1; i++)
      vecs.push_back(mk("cnt_run",  0,0,0,KIND_ALU, 0,  1,16,0,0,   S_NO,  S_NO,  1,1));
    vecs.push_back(mk("mdu16_fwd",  0,0,0,KIND_ALU, 0,  1,16,0,0,   S_EX,  S_NO,  0,0));
    vecs.push_back(mk("mdu16_mem",  0,0,0,KIND_ALU, 0,  1,16,0,0,   S_MEM, S_NO,  0,0));

    // Reset state with an ID instruction already requesting rs=$8 / rt=$8.
    drive(mk("rst", 0,0,1,KIND_ALU,8, 1,8,1,8, S_NO,S_NO,0,0), 0);
    repeat (2) @(negedge clk);
    e = '{name:"reset", frs:1'b0, frt:1'b0, drs:32'h0, drt:32'h0, st:1'b0, bu:1'b0};
    check_outputs(e);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i], i);
      e.name = $sformatf("v%0d_%s", i, vecs[i].name);
      e.frs  = src_fwd(vecs[i].srs);
      e.frt  = src_fwd(vecs[i].srt);
      e.drs  = src_data(vecs[i].srs, i);
      e.drt  = src_data(vecs[i].srt, i);
      e.st   = vecs[i].st;
      e.bu   = vecs[i].bu;
      sbq.push_back(e);
      @(negedge clk);
      got = sbq.pop_front();
      check_outputs(got);
    end

    // MDU latency measured with a bounded wait, then forwarding of the finished result.
    @(posedge clk);
    #1;
    drive(mk("mdu20", 0,0,1,KIND_MDU,20, 0,0,0,0, S_NO,S_NO,0,0), 0);
    bus.ex_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.id_valid  = 1'b0;
    bus.id_wreg   = 1'b0;
    bus.id_use_rs = 1'b1;
    bus.id_rs     = 5'd20;
    cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.mdu_busy) break;
      cycles++;
    end
    chk32("mdu_busy_cycles", 32'(cycles), 32'(MDU_LAT - 1));
    chk1 ("mdu_done/forward_rs", bus.forward_rs, 1'b1);
    chk32("mdu_done/forward_rs_data", bus.forward_rs_data, 32'h1234_5678);
    chk1 ("mdu_done/stall", bus.stall, 1'b0);

    // Reset asserted while an MDU op is counting.
    @(posedge clk);
    #1;
    bus.id_valid  = 1'b1;
    bus.id_wreg   = 1'b1;
    bus.id_kind   = KIND_MDU;
    bus.id_waddr  = 5'd21;
    bus.id_use_rs = 1'b0;
    @(posedge clk);
    #1;
    bus.id_valid  = 1'b0;
    bus.id_wreg   = 1'b0;
    bus.id_use_rs = 1'b1;
    bus.id_rs     = 5'd21;
    @(negedge clk);
    chk1("pre_reset/mdu_busy", bus.mdu_busy, 1'b1);
    chk1("pre_reset/stall", bus.stall, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk1("mid_reset/mdu_busy", bus.mdu_busy, 1'b0);
    chk1("mid_reset/stall", bus.stall, 1'b0);
    chk1("mid_reset/forward_rs", bus.forward_rs, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk1("post_reset/mdu_busy", bus.mdu_busy, 1'b0);
    chk1("post_reset/stall", bus.stall, 1'b0);
    chk1("post_reset/forward_rs", bus.forward_rs, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
